branch_control_unit: RTL
========================

# branch_control_unit

Parametrised next-generation sequencing FSM for the simple processor: fetches, decodes and executes one instruction at a time from `IR_out`, driving the datapath mux select, register load enables, ALU mode and memory strobes. Over the previous control unit it adds conditional/unconditional PC-relative branches, a flag-register load strobe, a memory wait-state handshake, parametrised instruction width and register count, and fully defined outputs (no X). It sits between the instruction register/flag register and the shared datapath bus.

## Interface
- `IR_W`, 16: instruction width; fields: inst=`IR_out[IR_W-1:IR_W-3]`, imm=`[IR_W-4]`, RX=`[IR_W-5:IR_W-7]`, RY=`[2:0]`.
- `NUM_REGS`, 8: general registers (1..8); register `NUM_REGS-1` is the PC.
- `MEM_WAIT`, 1: 1 = honour `mem_ready`; 0 = treat `mem_ready` as always 1.
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `run` in 1: start/continue execution.
- `IR_out` in IR_W: current instruction.
- `cout`, `z_flag`, `n_flag` in 1 each: registered ALU flags.
- `mem_ready` in 1: memory read data valid / write accepted.
- `sel` out 4: bus source: 0..NUM_REGS-1 register, 1000 IR immediate, 1001 G, 1010 DIN; 0000 when idle.
- `op` out 2: 00 add/sub, 01 AND; default 00.
- `add_sub_ctrl` out 1: 0 add, 1 subtract; default 0.
- `IR_in`, `A_in`, `G_in`, `F_in`, `ADDR_in`, `DOUT_in`, `PC_in` out 1 each: active-low load enables; default 1.
- `RX_in` out NUM_REGS: active-low per-register load; default all 1.
- `pc_incr` out 1: active-high PC increment.
- `W_inp` out 1: active-high memory write.
- `done` out 1: final cycle of instruction.
- `busy` out 1: high in any state except IDLE.
- `illegal` out 1: one-cycle pulse when RX/RY field ≥ NUM_REGS; instruction then completes with no register write.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5. Outputs are a combinational function of state, `IR_out`, flags; every output has a defined default in every state.
- IDLE: `run`=1 → T0, else stay.
- T0: sel=PC, ADDR_in=0, pc_incr=1 → T1.
- T1: wait; stay while `mem_ready`=0 → T2.
- T2: IR_in=0 → T3.
- Opcodes: MV 000, MVT 001, ADD 010, SUB 011, LD 100, ST 101, AND 110, B 111.
- T3: MV: sel = imm ? 1000 : RY, RX_in[RX]=0, done. MVT: sel=1000, RX_in[RX]=0, done. ADD/SUB/AND: sel=RX, A_in=0. LD/ST: sel=RY, ADDR_in=0. B: evaluate condition (RX field: 000 always, 001 z, 010 !z, 011 !cout, 100 cout, 101 !n, 110 n, 111 never); false → done; true → sel=PC, A_in=0.
- T4: ADD/SUB/AND: sel = imm ? 1000 : RY, G_in=0, F_in=0, add_sub_ctrl=1 only for SUB, op=01 for AND else 00. ST: sel=RX, DOUT_in=0, W_inp=1; hold in T4 while `mem_ready`=0; done in cycle `mem_ready`=1. LD: wait; hold while `mem_ready`=0. B: sel=1000, op=00, add_sub_ctrl=0, G_in=0 (F_in stays 1).
- T5: ADD/SUB/AND: sel=1001, RX_in[RX]=0, done. LD: sel=1010, RX_in[RX]=0, done. B: sel=1001, PC_in=0, done.
- After done: `run`=1 → T0, else IDLE. `run` dropping mid-instruction does not abort; instruction completes.
- `reset_n`=0: immediately IDLE; all outputs to defaults, `busy`=0, `done`=0.

## Timing
- Cycles with zero wait states (T0 to done inclusive): MV/MVT 4; ADD/SUB/AND 6; LD 6; ST 5; B not taken 4; B taken 6.
- Each `mem_ready`=0 cycle in T1, T4(LD), T4(ST) adds one cycle; strobes held constant while waiting.
- `illegal` asserted in T3 of the offending instruction; suppresses `RX_in` writes and reads use sel=0.
- `done` is high exactly one cycle per instruction; next T0 follows on the next edge.
- Reset asserted asynchronously mid-instruction: outputs default within the same cycle; release → IDLE until `run`.

## Test plan
- Reset, run=1, IR=MV R2,#5 (imm) → T3 sel=1000, RX_in=11111011, done at cycle 4; back to T0.
- ADD R1,R3 → T3 A_in=0 sel=1; T4 G_in=0 F_in=0 add_sub_ctrl=0 sel=3; T5 sel=1001 RX_in[1]=0 done.
- BEQ with z_flag=0 → done in T3, PC_in stays 1; same with z_flag=1 → T5 PC_in=0 sel=1001, 6 cycles total.
- LD with mem_ready low 3 cycles in T1 and 2 in T4 → done at cycle 11; ADDR_in/sel stable during waits.
- ST then run=0 → W_inp=1 one cycle, done, state IDLE, busy=0.
- NUM_REGS=4, MV R6,R1 → illegal pulse, RX_in=1111; reset_n pulsed low in T4 of ADD → IDLE, all enables 1, no RX write.

Source files
------------

// File: rtl/branch_control_unit_if.sv
// ============================================================================
// Module   : branch_control_unit_if
// Brief    : Control bus between sequencer, instruction/flag registers and datapath
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_control_unit_if #(
    parameter int IR_W     = 16,
    parameter int NUM_REGS = 8
) ();
    logic                run;
    logic [IR_W-1:0]     IR_out;
    logic                cout;
    logic                z_flag;
    logic                n_flag;
    logic                mem_ready;
    logic [3:0]          sel;
    logic [1:0]          op;
    logic                add_sub_ctrl;
    logic                IR_in;
    logic                A_in;
    logic                G_in;
    logic                F_in;
    logic                ADDR_in;
    logic                DOUT_in;
    logic                PC_in;
    logic [NUM_REGS-1:0] RX_in;
    logic                pc_incr;
    logic                W_inp;
    logic                done;
    logic                busy;
    logic                illegal;

    modport master (
        input  run, IR_out, cout, z_flag, n_flag, mem_ready,
        output sel, op, add_sub_ctrl, IR_in, A_in, G_in, F_in, ADDR_in,
               DOUT_in, PC_in, RX_in, pc_incr, W_inp, done, busy, illegal
    );

    modport slave (
        output run, IR_out, cout, z_flag, n_flag, mem_ready,
        input  sel, op, add_sub_ctrl, IR_in, A_in, G_in, F_in, ADDR_in,
               DOUT_in, PC_in, RX_in, pc_incr, W_inp, done, busy, illegal
    );
endinterface

`default_nettype wire

// File: rtl/branch_control_unit.sv
// ============================================================================
// Module   : branch_control_unit
// Brief    : Fetch/decode/execute sequencer with PC-relative branches and memory wait states
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_control_unit #(
    parameter int IR_W     = 16,
    parameter int NUM_REGS = 8,
    parameter int MEM_WAIT = 1
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    branch_control_unit_if.master   bus
);
    localparam logic [2:0] c_OP_MV  = 3'b000;
    localparam logic [2:0] c_OP_MVT = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b011;
    localparam logic [2:0] c_OP_LD  = 3'b100;
    localparam logic [2:0] c_OP_ST  = 3'b101;
    localparam logic [2:0] c_OP_AND = 3'b110;
    localparam logic [2:0] c_OP_B   = 3'b111;

    localparam logic [3:0] c_SEL_PC  = 4'(NUM_REGS - 1);
    localparam logic [3:0] c_SEL_IMM = 4'b1000;
    localparam logic [3:0] c_SEL_G   = 4'b1001;
    localparam logic [3:0] c_SEL_DIN = 4'b1010;

    localparam logic [NUM_REGS-1:0] c_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [2:0]          w_inst;
    logic                w_imm;
    logic [2:0]          w_rx;
    logic [2:0]          w_ry;
    logic                w_mem_rdy;
    logic                w_rx_bad;
    logic                w_ry_bad;
    logic                w_ry_used;
    logic                w_illegal;
    logic [3:0]          w_sel_rx;
    logic [3:0]          w_sel_ry;
    logic [NUM_REGS-1:0] w_rx_wr;
    logic                w_cond;
    logic                w_fin;
    logic                w_unused_ir;

    logic [3:0]          w_sel;
    logic [1:0]          w_op;
    logic                w_asc;
    logic                w_ir_in;
    logic                w_a_in;
    logic                w_g_in;
    logic                w_f_in;
    logic                w_addr_in;
    logic                w_dout_in;
    logic                w_pc_in;
    logic [NUM_REGS-1:0] w_rx_in;
    logic                w_pc_incr;
    logic                w_w_inp;
    logic                w_ill_o;

    assign w_inst      = bus.IR_out[IR_W-1 -: 3];
    assign w_imm       = bus.IR_out[IR_W-4];
    assign w_rx        = bus.IR_out[IR_W-5 -: 3];
    assign w_ry        = bus.IR_out[2:0];
    assign w_unused_ir = ^{bus.IR_out[IR_W-8:3], bus.mem_ready};
    assign w_mem_rdy   = (MEM_WAIT == 0) ? 1'b1 : bus.mem_ready;

    // Out-of-range register fields read as R0 and never produce a register write.
    assign w_rx_bad  = (int'(w_rx) >= NUM_REGS);
    assign w_ry_bad  = (int'(w_ry) >= NUM_REGS);
    assign w_ry_used = ((w_inst == c_OP_MV) && !w_imm) ||
                       (((w_inst == c_OP_ADD) || (w_inst == c_OP_SUB) ||
                         (w_inst == c_OP_AND)) && !w_imm) ||
                       (w_inst == c_OP_LD) || (w_inst == c_OP_ST);
    assign w_illegal = ((w_inst != c_OP_B) && w_rx_bad) || (w_ry_used && w_ry_bad);
    assign w_sel_rx  = w_rx_bad ? 4'd0 : {1'b0, w_rx};
    assign w_sel_ry  = w_ry_bad ? 4'd0 : {1'b0, w_ry};
    assign w_rx_wr   = w_illegal ? '1 : ~(c_ONE << w_rx);

    always_comb begin
        w_cond = 1'b0;
        case (w_rx)
            3'd0:    w_cond = 1'b1;
            3'd1:    w_cond = bus.z_flag;
            3'd2:    w_cond = !bus.z_flag;
            3'd3:    w_cond = !bus.cout;
            3'd4:    w_cond = bus.cout;
            3'd5:    w_cond = !bus.n_flag;
            3'd6:    w_cond = bus.n_flag;
            default: w_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_sel     = 4'd0;
        w_op      = 2'b00;
        w_asc     = 1'b0;
        w_ir_in   = 1'b1;
        w_a_in    = 1'b1;
        w_g_in    = 1'b1;
        w_f_in    = 1'b1;
        w_addr_in = 1'b1;
        w_dout_in = 1'b1;
        w_pc_in   = 1'b1;
        w_rx_in   = '1;
        w_pc_incr = 1'b0;
        w_w_inp   = 1'b0;
        w_ill_o   = 1'b0;
        w_fin     = 1'b0;
        case (r_state)
            S_IDLE: if (bus.run) w_next = S_T0;
            S_T0: begin
                w_sel     = c_SEL_PC;
                w_addr_in = 1'b0;
                w_pc_incr = 1'b1;
                w_next    = S_T1;
            end
            S_T1: if (w_mem_rdy) w_next = S_T2;
            S_T2: begin
                w_ir_in = 1'b0;
                w_next  = S_T3;
            end
            S_T3: begin
                w_ill_o = w_illegal;
                case (w_inst)
                    c_OP_MV: begin
                        w_sel   = w_imm ? c_SEL_IMM : w_sel_ry;
                        w_rx_in = w_rx_wr;
                        w_fin   = 1'b1;
                    end
                    c_OP_MVT: begin
                        w_sel   = c_SEL_IMM;
                        w_rx_in = w_rx_wr;
                        w_fin   = 1'b1;
                    end
                    c_OP_ADD, c_OP_SUB, c_OP_AND: begin
                        w_sel  = w_sel_rx;
                        w_a_in = 1'b0;
                        w_next = S_T4;
                    end
                    c_OP_LD, c_OP_ST: begin
                        w_sel     = w_sel_ry;
                        w_addr_in = 1'b0;
                        w_next    = S_T4;
                    end
                    default: begin
                        if (w_cond) begin
                            w_sel  = c_SEL_PC;
                            w_a_in = 1'b0;
                            w_next = S_T4;
                        end else begin
                            w_fin = 1'b1;
                        end
                    end
                endcase
            end
            S_T4: begin
                case (w_inst)
                    c_OP_ADD, c_OP_SUB, c_OP_AND: begin
                        w_sel  = w_imm ? c_SEL_IMM : w_sel_ry;
                        w_g_in = 1'b0;
                        w_f_in = 1'b0;
                        w_asc  = (w_inst == c_OP_SUB);
                        w_op   = (w_inst == c_OP_AND) ? 2'b01 : 2'b00;
                        w_next = S_T5;
                    end
                    c_OP_ST: begin
                        w_sel     = w_sel_rx;
                        w_dout_in = 1'b0;
                        w_w_inp   = 1'b1;
                        w_fin     = w_mem_rdy;
                    end
                    c_OP_LD: if (w_mem_rdy) w_next = S_T5;
                    c_OP_B: begin
                        // Branch target = PC + immediate offset; flags must not change.
                        w_sel  = c_SEL_IMM;
                        w_g_in = 1'b0;
                        w_next = S_T5;
                    end
                    default: w_next = S_IDLE;
                endcase
            end
            S_T5: begin
                case (w_inst)
                    c_OP_ADD, c_OP_SUB, c_OP_AND: begin
                        w_sel   = c_SEL_G;
                        w_rx_in = w_rx_wr;
                        w_fin   = 1'b1;
                    end
                    c_OP_LD: begin
                        w_sel   = c_SEL_DIN;
                        w_rx_in = w_rx_wr;
                        w_fin   = 1'b1;
                    end
                    c_OP_B: begin
                        w_sel   = c_SEL_G;
                        w_pc_in = 1'b0;
                        w_fin   = 1'b1;
                    end
                    default: w_next = S_IDLE;
                endcase
            end
            default: w_next = S_IDLE;
        endcase
        if (w_fin) w_next = bus.run ? S_T0 : S_IDLE;
    end

    assign bus.sel          = w_sel;
    assign bus.op           = w_op;
    assign bus.add_sub_ctrl = w_asc;
    assign bus.IR_in        = w_ir_in;
    assign bus.A_in         = w_a_in;
    assign bus.G_in         = w_g_in;
    assign bus.F_in         = w_f_in;
    assign bus.ADDR_in      = w_addr_in;
    assign bus.DOUT_in      = w_dout_in;
    assign bus.PC_in        = w_pc_in;
    assign bus.RX_in        = w_rx_in;
    assign bus.pc_incr      = w_pc_incr;
    assign bus.W_inp        = w_w_inp;
    assign bus.done         = w_fin;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.illegal      = w_ill_o;

endmodule

`default_nettype wire
